// File: rtl/counter_sequencer_if.sv
// rtl/counter_sequencer_if.sv - operator/datapath side bundle of the counter sequencer
interface counter_sequencer_if #(
    parameter int WIDTH = 3
);
    logic             START;
    logic             STOP;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] LIMIT;
    logic [WIDTH-1:0] CNT;
    logic             EN_N;
    logic             CCLR_N;
    logic             BUSY;
    logic             DONE;
    logic             WRAP;
    logic [2:0]       STATE;

    modport master (
        output START, STOP, MODE, LIMIT, CNT,
        input  EN_N, CCLR_N, BUSY, DONE, WRAP, STATE
    );

    modport slave (
        input  START, STOP, MODE, LIMIT, CNT,
        output EN_N, CCLR_N, BUSY, DONE, WRAP, STATE
    );
endinterface

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - control FSM sequencing a D-flop counter (free-run, one-shot, step)
module counter_sequencer #(
    parameter int WIDTH        = 3,
    parameter bit AUTO_RESTART = 1'b0
) (
    input logic                CK,
    input logic                CLR,
    counter_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             armed;
    logic             accept;
    logic             start_ok;
    logic             terminal;
    logic [WIDTH-1:0] limit_m1;
    logic             en_n, cclr_n, busy, done, wrap;
    logic [2:0]       state_out;

    // START is honoured once per assertion: armed drops on acceptance and returns when START is seen low
    assign start_ok = bus.START && armed && !bus.STOP && (bus.MODE != 2'b11);
    assign limit_m1 = bus.LIMIT - WIDTH'(1);
    assign terminal = (bus.CNT == limit_m1);

    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    accept  = 1'b1;
                    mode_d  = bus.MODE;
                    state_d = (bus.MODE == 2'b10) ? STEP : CLEAR;
                end
            end
            CLEAR: state_d = bus.STOP ? IDLE : RUN;
            STEP:  state_d = IDLE;
            RUN: begin
                if (bus.STOP)
                    state_d = IDLE;
                else if (mode_q == 2'b01 && terminal)
                    state_d = DONE;
            end
            DONE: begin
                if (bus.STOP) begin
                    state_d = IDLE;
                end else if (AUTO_RESTART) begin
                    state_d = CLEAR;
                end else if (start_ok) begin
                    accept  = 1'b1;
                    mode_d  = bus.MODE;
                    state_d = (bus.MODE == 2'b10) ? STEP : CLEAR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change with the state register itself
    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            state     <= IDLE;
            mode_q    <= 2'b00;
            armed     <= 1'b1;
            en_n      <= 1'b1;
            cclr_n    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            state_out <= 3'd0;
        end else begin
            state     <= state_d;
            mode_q    <= mode_d;
            armed     <= accept ? 1'b0 : (!bus.START ? 1'b1 : armed);
            en_n      <= !(state_d == RUN || state_d == STEP);
            cclr_n    <= (state_d != CLEAR);
            busy      <= (state_d == CLEAR || state_d == RUN || state_d == STEP);
            done      <= (state_d == DONE);
            wrap      <= !en_n && (bus.CNT == {WIDTH{1'b1}});
            state_out <= state_d;
        end
    end

    assign bus.EN_N   = en_n;
    assign bus.CCLR_N = cclr_n;
    assign bus.BUSY   = busy;
    assign bus.DONE   = done;
    assign bus.WRAP   = wrap;
    assign bus.STATE  = state_out;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - table-driven bench for counter_sequencer with D-flop counter models
module tb_counter_sequencer;
    localparam logic [2:0] S_I = 3'd0, S_C = 3'd1, S_R = 3'd2, S_S = 3'd3, S_D = 3'd4;

    typedef struct {
        bit         dut;
        logic       start;
        logic       stop;
        logic [1:0] mode;
        logic [2:0] limit;
        logic       ld;
        logic [2:0] ldv;
        logic [2:0] st;
        logic [2:0] cnt;
        logic       wrap;
    } vec_t;

    logic ck = 1'b0;
    logic clr = 1'b0;
    logic lda = 1'b0, ldb = 1'b0;
    logic [2:0] ldva = 3'd0, ldvb = 3'd0;
    logic [2:0] cnta = 3'd0, cntb = 3'd0;
    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    counter_sequencer_if #(.WIDTH(3)) ifa ();
    counter_sequencer_if #(.WIDTH(3)) ifb ();

    counter_sequencer #(.WIDTH(3), .AUTO_RESTART(1'b0)) dut_a (.CK(ck), .CLR(clr), .bus(ifa));
    counter_sequencer #(.WIDTH(3), .AUTO_RESTART(1'b1)) dut_b (.CK(ck), .CLR(clr), .bus(ifb));

    always #5 ck = ~ck;

    // Counter datapath: load is a bench-only preset path
    always @(posedge ck) begin
        if (lda) cnta <= ldva;
        else if (!ifa.CCLR_N) cnta <= 3'd0;
        else if (!ifa.EN_N) cnta <= cnta + 3'd1;
    end
    always @(posedge ck) begin
        if (ldb) cntb <= ldvb;
        else if (!ifb.CCLR_N) cntb <= 3'd0;
        else if (!ifb.EN_N) cntb <= cntb + 3'd1;
    end
    assign ifa.CNT = cnta;
    assign ifb.CNT = cntb;

    function automatic vec_t v(bit d, logic s, logic p, logic [1:0] m, logic [2:0] l,
                               logic ld, logic [2:0] ldv, logic [2:0] st, logic [2:0] c, logic w);
        vec_t r;
        r.dut = d; r.start = s; r.stop = p; r.mode = m; r.limit = l;
        r.ld = ld; r.ldv = ldv; r.st = st; r.cnt = c; r.wrap = w;
        return r;
    endfunction

    task automatic chk(string nm, int idx, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic check_outs(int idx, bit d, logic [2:0] st, logic [2:0] c, logic w);
        logic [2:0] a_st, a_cnt;
        logic a_en, a_cc, a_busy, a_done, a_wrap;
        if (d) begin
            a_st = ifb.STATE; a_cnt = cntb; a_en = ifb.EN_N; a_cc = ifb.CCLR_N;
            a_busy = ifb.BUSY; a_done = ifb.DONE; a_wrap = ifb.WRAP;
        end else begin
            a_st = ifa.STATE; a_cnt = cnta; a_en = ifa.EN_N; a_cc = ifa.CCLR_N;
            a_busy = ifa.BUSY; a_done = ifa.DONE; a_wrap = ifa.WRAP;
        end
        chk("state", idx, 8'(a_st), 8'(st));
        chk("cnt", idx, 8'(a_cnt), 8'(c));
        chk("en_n", idx, 8'(a_en), 8'(!(st == S_R || st == S_S)));
        chk("cclr_n", idx, 8'(a_cc), 8'(st != S_C));
        chk("busy", idx, 8'(a_busy), 8'(st == S_C || st == S_R || st == S_S));
        chk("done", idx, 8'(a_done), 8'(st == S_D));
        chk("wrap", idx, 8'(a_wrap), 8'(w));
    endtask

    task automatic apply(int idx, vec_t t);
        if (t.dut) begin
            ifb.START = t.start; ifb.STOP = t.stop; ifb.MODE = t.mode; ifb.LIMIT = t.limit;
            ldb = t.ld; ldvb = t.ldv; ifa.START = 1'b0; ifa.STOP = 1'b0; lda = 1'b0;
        end else begin
            ifa.START = t.start; ifa.STOP = t.stop; ifa.MODE = t.mode; ifa.LIMIT = t.limit;
            lda = t.ld; ldva = t.ldv; ifb.START = 1'b0; ifb.STOP = 1'b0; ldb = 1'b0;
        end
        @(posedge ck);
        #1;
        check_outs(idx, t.dut, t.st, t.cnt, t.wrap);
    endtask

    initial begin
        ifa.START = 1'b0; ifa.STOP = 1'b0; ifa.MODE = 2'b00; ifa.LIMIT = 3'd0;
        ifb.START = 1'b0; ifb.STOP = 1'b0; ifb.MODE = 2'b00; ifb.LIMIT = 3'd0;

        // free-run from a preset of 5, MODE/LIMIT/START wiggled mid-run, STOP at CNT=3
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 5, S_I, 5, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, S_C, 5, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, S_R, 0, 0));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(v(0, k == 5, 0, 1, 4, 0, 0, S_R, 3'(k), 0));
        tbl.push_back(v(0, 0, 0, 1, 4, 0, 0, S_R, 0, 1));
        for (int k = 1; k <= 3; k++)
            tbl.push_back(v(0, 0, 0, 1, 4, 0, 0, S_R, 3'(k), 0));
        tbl.push_back(v(0, 0, 1, 1, 4, 0, 0, S_I, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, S_I, 4, 0));
        // one-shot to LIMIT=5
        tbl.push_back(v(0, 1, 0, 1, 5, 0, 0, S_C, 4, 0));
        tbl.push_back(v(0, 0, 0, 1, 5, 0, 0, S_R, 0, 0));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(v(0, 0, 0, 1, 5, 0, 0, S_R, 3'(k), 0));
        tbl.push_back(v(0, 0, 0, 1, 5, 0, 0, S_D, 5, 0));
        tbl.push_back(v(0, 0, 0, 1, 5, 0, 0, S_D, 5, 0));
        tbl.push_back(v(0, 0, 1, 1, 5, 0, 0, S_I, 5, 0));
        // one-shot with LIMIT=0: full 8 advances, then restart from DONE in free-run
        tbl.push_back(v(0, 1, 0, 1, 0, 0, 0, S_C, 5, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, S_R, 0, 0));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, S_R, 3'(k), 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, S_D, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, S_D, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, S_C, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, S_R, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, S_I, 1, 0));
        // single step, START held then re-asserted
        tbl.push_back(v(0, 0, 0, 2, 0, 1, 6, S_I, 6, 0));
        tbl.push_back(v(0, 1, 0, 2, 0, 0, 0, S_S, 6, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(0, 1, 0, 2, 0, 0, 0, S_I, 7, 0));
        tbl.push_back(v(0, 0, 0, 2, 0, 0, 0, S_I, 7, 0));
        tbl.push_back(v(0, 1, 0, 2, 0, 0, 0, S_S, 7, 0));
        tbl.push_back(v(0, 0, 0, 2, 0, 0, 0, S_I, 0, 1));
        tbl.push_back(v(0, 0, 0, 2, 0, 0, 0, S_I, 0, 0));
        // STOP on the terminal edge, MODE 11, STOP blocking START, STOP in CLEAR
        tbl.push_back(v(0, 1, 0, 1, 3, 0, 0, S_C, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 3, 0, 0, S_R, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 3, 0, 0, S_R, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 3, 0, 0, S_R, 2, 0));
        tbl.push_back(v(0, 0, 1, 1, 3, 0, 0, S_I, 3, 0));
        tbl.push_back(v(0, 0, 0, 1, 3, 0, 0, S_I, 3, 0));
        tbl.push_back(v(0, 1, 0, 3, 3, 0, 0, S_I, 3, 0));
        tbl.push_back(v(0, 0, 0, 3, 3, 0, 0, S_I, 3, 0));
        tbl.push_back(v(0, 1, 1, 0, 3, 0, 0, S_I, 3, 0));
        tbl.push_back(v(0, 0, 0, 0, 3, 0, 0, S_I, 3, 0));
        tbl.push_back(v(0, 1, 0, 0, 3, 0, 0, S_C, 3, 0));
        tbl.push_back(v(0, 0, 1, 0, 3, 0, 0, S_I, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 3, 0, 0, S_I, 0, 0));
        // auto-restart instance, one-shot LIMIT=2, STOP in DONE
        tbl.push_back(v(1, 1, 0, 1, 2, 0, 0, S_C, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 2, 0, 0, S_R, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 2, 0, 0, S_R, 1, 0));
        tbl.push_back(v(1, 0, 0, 1, 2, 0, 0, S_D, 2, 0));
        tbl.push_back(v(1, 0, 0, 1, 2, 0, 0, S_C, 2, 0));
        tbl.push_back(v(1, 0, 0, 1, 2, 0, 0, S_R, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 2, 0, 0, S_R, 1, 0));
        tbl.push_back(v(1, 0, 0, 1, 2, 0, 0, S_D, 2, 0));
        tbl.push_back(v(1, 0, 1, 1, 2, 0, 0, S_I, 2, 0));
        tbl.push_back(v(1, 0, 0, 1, 2, 0, 0, S_I, 2, 0));

        repeat (2) @(posedge ck);
        #1;
        check_outs(1000, 1'b0, S_I, 3'd0, 1'b0);
        check_outs(1001, 1'b1, S_I, 3'd0, 1'b0);
        @(negedge ck);
        clr = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(i, tbl[i]);

        // asynchronous reset mid-RUN: outputs drop at once and the counter freezes
        apply(2000, v(0, 0, 0, 0, 0, 1, 0, S_I, 0, 0));
        apply(2001, v(0, 1, 0, 0, 0, 0, 0, S_C, 0, 0));
        apply(2002, v(0, 0, 0, 0, 0, 0, 0, S_R, 0, 0));
        apply(2003, v(0, 0, 0, 0, 0, 0, 0, S_R, 1, 0));
        #2;
        clr = 1'b0;
        #1;
        check_outs(2004, 1'b0, S_I, 3'd1, 1'b0);
        @(posedge ck);
        #1;
        check_outs(2005, 1'b0, S_I, 3'd1, 1'b0);
        @(negedge ck);
        clr = 1'b1;
        apply(2006, v(0, 0, 0, 0, 0, 0, 0, S_I, 1, 0));
        apply(2007, v(0, 0, 0, 0, 0, 0, 0, S_I, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Control FSM that sequences a WIDTH-bit synchronous ripple-free counter built from D flip-flops.
- Drives the counter's active-low enable (EN_N) and a synchronous-clear request (CCLR_N).
- Observes the counter value and supports free-run, one-shot-to-limit and single-step operation.
- Sits between the operator switches/push-buttons and the counter datapath; status outputs feed LEDs.

Parameters:
WIDTH, 3, counter width; CNT and LIMIT are WIDTH bits.
AUTO_RESTART, 0, 1 = one-shot mode re-arms automatically from DONE (DONE -> CLEAR).

Ports:
CK  input  1  clock; all state changes on rising edge.
CLR  input  1  reset CLR, asynchronous, active-low.
START  input  1  level, sampled each edge; starts the operation selected by MODE.
STOP  input  1  level, sampled each edge; aborts to IDLE.
MODE  input  2  00 free-run, 01 one-shot to LIMIT, 10 single step, 11 reserved (START ignored).
LIMIT  input  WIDTH  one-shot terminal value; 0 means full 2^WIDTH counts.
CNT  input  WIDTH  current counter value (counter Q outputs).
EN_N  output  1  counter enable, active-low; counter advances on an edge when EN_N=0.
CCLR_N  output  1  counter clear request, active-low, one cycle.
BUSY  output  1  1 in CLEAR, RUN, STEP.
DONE  output  1  1 in DONE state.
WRAP  output  1  one-cycle pulse after the counter advances from all-ones to 0.
STATE  output  3  state encoding for display/debug.

Behaviour:
- States and encodings: IDLE=0, CLEAR=1, RUN=2, STEP=3, DONE=4. All outputs are registered or pure state decodes; no input-to-output combinational paths.
- Reset (CLR=0, asynchronous):
  - State goes to IDLE; mode_q=00; WRAP=0.
  - Outputs: EN_N=1, CCLR_N=1, BUSY=0, DONE=0, STATE=0, immediately and held while CLR=0.
  - Reset mid-RUN freezes the counter in the same instant.
- Output decode:
  - EN_N=0 iff state is RUN or STEP.
  - CCLR_N=0 iff state is CLEAR.
  - BUSY per the Ports list; DONE iff state is DONE.
- MODE is captured into mode_q only on the edge that accepts START. Changes to MODE during RUN have no effect.
- IDLE:
  - START with MODE 00/01 -> CLEAR.
  - START with MODE 10 -> STEP.
  - MODE 11, or START=0 -> stay in IDLE.
  - STOP=1 blocks START (STOP wins).
- CLEAR: exactly one cycle with CCLR_N=0 and EN_N=1, then -> RUN, or -> IDLE if STOP=1.
- STEP: exactly one cycle with EN_N=0, so the counter advances by 1; then -> IDLE regardless of START. START held high does not re-step until it is seen low in IDLE (edge-qualified: one step per START assertion).
- RUN, free-run (mode_q=00): stay in RUN; -> IDLE on STOP. START is ignored.
- RUN, one-shot (mode_q=01):
  - On an edge with CNT == (LIMIT-1) mod 2^WIDTH, go -> DONE. The counter lands on LIMIT at that same edge, and EN_N=1 from then on, so the counter holds at LIMIT.
  - LIMIT=0 gives 2^WIDTH advances (stops at 0).
- STOP precedence: STOP in RUN -> IDLE. The counter still advances on that edge, because EN_N was 0 during the cycle. STOP coincident with the terminal condition -> IDLE and DONE stays 0.
- DONE:
  - Hold; EN_N=1.
  - START (edge-qualified) -> CLEAR using the new MODE.
  - STOP -> IDLE.
  - AUTO_RESTART=1 -> CLEAR unconditionally next edge, unless STOP=1.
- WRAP: registered; set for one cycle after an edge where EN_N=0 and CNT=all-ones, otherwise 0.
- CNT is assumed settled (including the counter's clock-to-Q delay) before each rising edge. CNT is sampled only on rising CK edges.

Test Plan:
1. Reset/idle: CLR=0 during a RUN -> EN_N=1, BUSY=0, STATE=0 immediately. Release CLR with START=0 -> stays IDLE, counter frozen.
2. Free-run: CNT=5, MODE=00, pulse START -> one cycle CCLR_N=0 (CNT=0), then CNT 0,1,..,7,0. WRAP high exactly one cycle after 7->0. STOP at CNT=3 -> IDLE, CNT ends at 4.
3. One-shot: MODE=01, LIMIT=5, START -> counter 0..5 then holds at 5, DONE=1 and EN_N=1 from that edge. Repeat with LIMIT=0 -> 8 advances, stops at 0, WRAP pulses once.
4. Step: MODE=10, CNT=6, START held high 4 cycles -> CNT=7 only. Release then reassert -> CNT=0 with WRAP=1.
5. Corner cases: STOP asserted on the terminal edge (LIMIT=3, CNT=2) -> IDLE, DONE=0, CNT=3. MODE=11 with START -> no state change. MODE changed during RUN -> behaviour unchanged.
6. AUTO_RESTART=1, MODE=01, LIMIT=2 -> repeating sequence: CLEAR, 0, 1, 2, DONE, CLEAR... STOP during DONE -> IDLE.
